// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data memory.
// Optional macro DMEM_ARB_LOCK_EN adds m0_lock for atomic read-modify-write by port 0.
`ifndef DSIZE
`define DSIZE 16
`endif

module dmem_arbiter #(
  parameter int AW        = `DSIZE,
  parameter int DW        = `DSIZE,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
`endif
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last;
  logic [3:0]    burst_cnt;
  logic [1:0]    rd_tag;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          g0, g1;
  logic          under;
  logic          lock0;
  logic [3:0]    cnt_inc;

  assign under   = burst_cnt < 4'(MAX_BURST - 1);
  assign cnt_inc = (burst_cnt == 4'hf) ? burst_cnt : burst_cnt + 4'd1;

`ifdef DMEM_ARB_LOCK_EN
  assign lock0 = (state == OWN0) && m0_lock;
`else
  assign lock0 = 1'b0;
`endif

  // Grant select; the owner keeps the port until its burst budget runs out.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      OWN0: begin
        g0 = m0_req && (lock0 || !m1_req || under);
        g1 = !g0 && m1_req;
      end
      OWN1: begin
        g1 = m1_req && (!m0_req || under);
        g0 = !g1 && m0_req;
      end
      default: begin
        g0 = m0_req && (!m1_req || last);
        g1 = m1_req && (!m0_req || !last);
      end
    endcase
    if (!rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign mem_wen   = (g0 && m0_wen) || (g1 && m1_wen);
  assign mem_addr  = g0 ? m0_addr  : (g1 ? m1_addr  : addr_q);
  assign mem_wdata = g0 ? m0_wdata : (g1 ? m1_wdata : wdata_q);
  assign m0_rvalid = rd_tag[0] && rst;
  assign m1_rvalid = rd_tag[1] && rst;
  assign rdata     = mem_rdata;

  // Ownership, burst count, held memory drive and pending-read tags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
      rd_tag    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rd_tag <= {g1 && !m1_wen, g0 && !m0_wen};
      if (g0 || g1) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (g0) begin
        state     <= OWN0;
        last      <= 1'b0;
        burst_cnt <= (state == OWN0) ? cnt_inc : 4'd0;
      end else if (g1) begin
        state     <= OWN1;
        last      <= 1'b1;
        burst_cnt <= (state == OWN1) ? cnt_inc : 4'd0;
      end else begin
        state     <= IDLE;
        burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter in front of the single-port data memory (one write-enable, one address, registered read address, read data one cycle later).
- Port 0 is the pipeline load/store stage; port 1 is a secondary master (debug/DMA loader).
- Grants one access per cycle with a burst limit, muxes address, write data and write-enable to the memory, and routes the delayed read data back as a tagged response.

Parameters:
- AW, `DSIZE (16): address width.
- DW, `DSIZE (16): data width.
- MAX_BURST, 4: maximum consecutive grants to one port while the other port is requesting (range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- m0_req  in  1  port 0 access request; held until granted.
- m0_wen  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  AW  port 0 word address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 granted this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid on rdata (registered).
- m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as port 0, for port 1.
- rdata  out  DW  read data, shared by both ports; qualified by mX_rvalid.
- mem_wen  out  1  to memory wen.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory data_in.
- mem_rdata  in  DW  from memory data_out.

Behaviour:
- State: a 3-state FSM, IDLE / OWN0 / OWN1. Supporting registers:
  - last (port last served); resets to 1, so port 0 wins the first tie.
  - burst_cnt, 4 bits.
  - rd_tag, 2 bits: bit0 = port 0 read pending, bit1 = port 1 read pending.
- Grant selection (combinational, evaluated each cycle):
  - IDLE: if only one port requests, grant it. If both request, grant the port not equal to last.
  - OWNx: grant x if x requests and either the other port does not request or burst_cnt < MAX_BURST-1. Otherwise grant the other port if it requests. Otherwise grant none.
- At most one mX_gnt is high per cycle.
- Memory drive:
  - Granted port drives mem_addr, mem_wdata and mem_wen.
  - With no grant: mem_wen = 0; mem_addr and mem_wdata hold the last granted values (no spurious address change).
- Write: takes effect at the edge ending the grant cycle.
- Read response:
  - Read granted in cycle t gives mX_rvalid = 1 in cycle t+1, with rdata = mem_rdata.
  - rdata is a pass-through of mem_rdata.
  - Back-to-back reads give back-to-back rvalid.
- State update at each edge:
  - Grant to x: state goes to OWNx and last = x. burst_cnt is cleared if the owner changed or was IDLE, otherwise incremented (saturating at 15).
  - No grant: state goes to IDLE and burst_cnt = 0.
- Reset (rst = 0 at an edge):
  - FSM = IDLE, last = 1, burst_cnt = 0, rd_tag = 0.
  - While rst = 0: m0_gnt = m1_gnt = 0, mem_wen = 0, m0_rvalid = m1_rvalid = 0. Gating is combinational on rst so nothing writes memory during its reset/load cycle.
  - A read granted in the cycle before reset asserts loses its rvalid; requester must reissue.
- Boundaries:
  - MAX_BURST = 1 gives strict alternation under contention.
  - A single requester is never throttled by burst_cnt.
  - A request dropped while not granted is legal; no state change.
  - Address wrap is not handled here; the memory is indexed directly.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - Adds input m0_lock (1 bit).
  - While state is OWN0 and m0_lock = 1, port 0 keeps the grant regardless of m1_req and burst_cnt, for atomic read-modify-write. burst_cnt still counts.
  - m0_lock is ignored when state is not OWN0.
- Undefined: no m0_lock port; behaviour exactly as above.

Test Plan:
- Reset hold: rst = 0 for 3 cycles with m0_req = 1, m0_wen = 1 -> m0_gnt = 0 and mem_wen = 0 every cycle. After rst = 1, first cycle m0_gnt = 1.
- Single read: m0 read of addr 0x0005, memory preloaded 0x00AB -> m0_gnt in cycle t; m0_rvalid = 1 with rdata = 0x00AB in t+1; m1_rvalid = 0.
- Contention, MAX_BURST = 4: both ports request continuously from IDLE after reset -> grants 0,0,0,0,1,1,1,1,0... No cycle has both grants; no cycle without a grant.
- Write then read across ports: m1 writes 0x1234 to 0x0010, then m0 reads 0x0010 in the next cycle -> m0 receives 0x1234 one cycle after its grant.
- Idle behaviour: requests drop for 2 cycles -> mem_wen = 0 and mem_addr unchanged; FSM IDLE. Then simultaneous requests with last = 0 -> port 1 granted.
- DMEM_ARB_LOCK_EN: m0 holds m0_lock = 1 for 6 grants with m1_req = 1 throughout -> m0 granted all 6. m1 granted the cycle after m0_lock drops.
